// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared types and constants for the PPU bus-side write queue.
//   tgt_e       : target decode of bus address[11:10]
//   wq_entry_t  : one queued write {sel, addr, data}
//   VACTIVE_LINES / VTOTAL_LINES : VGA vertical timing (lines)
// ---------------------------------------------------------------------------
package ppu_pkg;

    localparam int VACTIVE_LINES = 480;
    localparam int VTOTAL_LINES  = 525;

    typedef enum logic [1:0] {
        TGT_ATTR   = 2'd0,
        TGT_SPRITE = 2'd1,
        TGT_COLOR  = 2'd2,
        TGT_CTRL   = 2'd3
    } tgt_e;

    typedef struct packed {
        tgt_e        sel;
        logic [9:0]  addr;
        logic [31:0] data;
    } wq_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// ---------------------------------------------------------------------------
// wq_fifo
// Synchronous FIFO of wq_entry_t. Storage is a plain array so it maps onto
// block RAM; the head entry is delivered through a registered read port that
// only advances on a pop, so pop_data is valid the cycle after the pop.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, push_data    : enqueue at the tail (ignored when full without pop)
//   pop                : dequeue the head (ignored when empty)
//   pop_data           : registered copy of the last popped entry
//   full, empty, count : occupancy status, count in 0..DEPTH
// ---------------------------------------------------------------------------
module wq_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wq_entry_t push_data,
    input  logic      pop,
    output wq_entry_t pop_data,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    wq_entry_t       mem [DEPTH];
    wq_entry_t       pop_data_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_ok, pop_ok;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // RAM write port; no reset so the array stays a plain memory.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // RAM read port. When full, push and pop hit the same slot; the read
    // returns the old (head) entry because both updates are non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_data_q <= '0;
        end else if (pop_ok) begin
            pop_data_q <= mem[rd_ptr_q];
        end
    end

    assign pop_data = pop_data_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/ppu_write_queue.sv
// ---------------------------------------------------------------------------
// ppu_write_queue
// Bus-side write buffer in front of the PPU attribute/sprite/color tables.
// Bus writes are queued at any time and replayed into the PPU memory write
// port only inside the vertical blanking window (or always, in bypass mode).
// Address space: address[11:10] = 0 attr, 1 sprite, 2 color, 3 control.
//   control addr[0]=0 : bypass <= writedata[0]
//   control addr[0]=1 : clear irq (only with the irq feature)
// Build option: define PPU_WQ_VBLANK_IRQ_EN to build the vblank interrupt;
// without it irq is tied low and no edge detect exists.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   writedata/write/chipselect/address/waitrequest : Avalon-style slave
//   vcount                         : current VGA line
//   mem_write/w_address/w_data     : PPU memory write port (registered)
//   fifo_level                     : queued entry count, 0..DEPTH
//   irq                            : vblank interrupt
// ---------------------------------------------------------------------------
module ppu_write_queue
    import ppu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int VACTIVE = VACTIVE_LINES,
    parameter int VGUARD  = VTOTAL_LINES - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   writedata,
    input  logic          write,
    input  logic          chipselect,
    input  logic [11:0]   address,
    output logic          waitrequest,
    input  logic [9:0]    vcount,
    output logic [2:0]    mem_write,
    output logic [11:0]   w_address,
    output logic [31:0]   w_data,
    output logic [AW:0]   fifo_level,
    output logic          irq
);

    localparam logic [9:0] VACTIVE_L = 10'(VACTIVE);
    localparam logic [9:0] VGUARD_L  = 10'(VGUARD);

    tgt_e      bus_tgt;
    logic      data_req, ctrl_wr, drain_ok;
    logic      push, pop;
    logic      fifo_full, fifo_empty;
    wq_entry_t push_entry, head;
    logic      bypass_q, bypass_d;
    logic      strobe_q, strobe_d;

    always_comb begin
        bus_tgt  = tgt_e'(address[11:10]);
        data_req = chipselect && write && (bus_tgt != TGT_CTRL);
        ctrl_wr  = chipselect && write && (bus_tgt == TGT_CTRL);

        // The window stops one line short of the frame end so the strobe
        // issued from the last pop still lands inside blanking.
        drain_ok = bypass_q || ((vcount >= VACTIVE_L) && (vcount <= VGUARD_L));

        pop  = !fifo_empty && drain_ok;
        // A same-cycle pop frees a slot, so a full FIFO only stalls when idle.
        push        = data_req && (!fifo_full || pop);
        waitrequest = data_req && fifo_full && !pop;

        push_entry.sel  = bus_tgt;
        push_entry.addr = address[9:0];
        push_entry.data = writedata;

        bypass_d = bypass_q;
        if (ctrl_wr && !address[0]) begin
            bypass_d = writedata[0];
        end

        strobe_d = pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bypass_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
            strobe_q <= strobe_d;
        end
    end

    wq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level)
    );

    // The FIFO read register doubles as the address/data output register:
    // it only changes on a pop, so the values hold between strobes.
    assign w_address = {head.sel, head.addr};
    assign w_data    = head.data;

    for (genvar gi = 0; gi < 3; gi++) begin : g_we
        assign mem_write[gi] = strobe_q && (head.sel == 2'(gi));
    end

`ifdef PPU_WQ_VBLANK_IRQ_EN
    logic [9:0] vcount_prev_q, vcount_prev_d;
    logic       irq_q, irq_d;

    localparam logic [9:0] VLAST_ACTIVE_L = 10'(VACTIVE - 1);

    always_comb begin
        vcount_prev_d = vcount;
        irq_d         = irq_q;
        if (ctrl_wr && address[0]) begin
            irq_d = 1'b0;
        end
        // Set is evaluated last so it wins over a clear in the same cycle.
        if ((vcount_prev_q == VLAST_ACTIVE_L) && (vcount == VACTIVE_L)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vcount_prev_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            vcount_prev_q <= vcount_prev_d;
            irq_q         <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_write_queue.sv
// Self-checking bench for ppu_write_queue: directed scenarios plus a
// randomized run checked against a queue-based behavioural model.
module tb_ppu_write_queue;
    import ppu_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef PPU_WQ_VBLANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   writedata = '0;
    logic          write = 1'b0;
    logic          chipselect = 1'b0;
    logic [11:0]   address = '0;
    logic          waitrequest;
    logic [9:0]    vcount = 10'd100;
    logic [2:0]    mem_write;
    logic [11:0]   w_address;
    logic [31:0]   w_data;
    logic [AW:0]   fifo_level;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    ppu_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .writedata  (writedata),
        .write      (write),
        .chipselect (chipselect),
        .address    (address),
        .waitrequest(waitrequest),
        .vcount     (vcount),
        .mem_write  (mem_write),
        .w_address  (w_address),
        .w_data     (w_data),
        .fifo_level (fifo_level),
        .irq        (irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
    endtask

    task automatic do_reset();
        idle();
        vcount = 10'd100;
        reset  = 1'b1;
        step();
        step();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        vcount = 10'd100;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        vectors++;
        if (mem_write !== 3'b000) begin miscompares++; $display("FAIL reset_mem_write: got %b expected 000", mem_write); end
        vectors++;
        if (w_address !== 12'h000) begin miscompares++; $display("FAIL reset_w_address: got %h expected 000", w_address); end
        vectors++;
        if (w_data !== 32'h0) begin miscompares++; $display("FAIL reset_w_data: got %h expected 0", w_data); end
        vectors++;
        if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL reset_waitrequest: got %b expected 0", waitrequest); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
        step();
    endtask

    task automatic test_vblank_drain();
        do_reset();
        bus_wr(12'h003, 32'hA5A5_0001);
        step();
        idle();
        vectors++;
        if (mem_write !== 3'b000) begin miscompares++; $display("FAIL drain_no_strobe: got %b expected 000", mem_write); end
        vectors++;
        if (fifo_level !== 5'd1) begin miscompares++; $display("FAIL drain_level1: got %0d expected 1", fifo_level); end
        step();
        vcount = 10'd480;
        step();
        vectors++;
        if (mem_write !== 3'b001) begin miscompares++; $display("FAIL drain_strobe: got %b expected 001", mem_write); end
        vectors++;
        if (w_address !== 12'h003) begin miscompares++; $display("FAIL drain_w_address: got %h expected 003", w_address); end
        vectors++;
        if (w_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL drain_w_data: got %h expected a5a50001", w_data); end
        vectors++;
        if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL drain_level0: got %0d expected 0", fifo_level); end
        step();
        vectors++;
        if (mem_write !== 3'b000) begin miscompares++; $display("FAIL drain_single_strobe: got %b expected 000", mem_write); end
        vectors++;
        if (w_address !== 12'h003) begin miscompares++; $display("FAIL drain_hold_addr: got %h expected 003", w_address); end
    endtask

    task automatic test_full_stall();
        int n;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus_wr(12'h800 + 12'(i), 32'hC0DE_0000 + 32'(i));
            #1;
            vectors++;
            if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL full_early_wait: entry %0d got %b expected 0", i, waitrequest); end
            step();
        end
        bus_wr(12'h810, 32'hC0DE_0010);
        #1;
        vectors++;
        if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL full_wait: got %b expected 1", waitrequest); end
        vectors++;
        if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_level: got %0d expected 16", fifo_level); end
        step();
        vectors++;
        if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL full_wait_held: got %b expected 1", waitrequest); end
        vcount = 10'd480;
        #1;
        vectors++;
        if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL full_pop_frees: got %b expected 0", waitrequest); end
        step();
        idle();
        vectors++;
        if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_push_pop_level: got %0d expected 16", fifo_level); end
        n = 0;
        for (int k = 0; k < 24; k++) begin
            if (mem_write !== 3'b000) begin
                vectors++;
                if (n >= 17 || mem_write !== 3'b100 || w_address !== 12'h800 + 12'(n) || w_data !== 32'hC0DE_0000 + 32'(n)) begin
                    miscompares++;
                    $display("FAIL full_order: strobe %0d got we=%b a=%h d=%h expected we=100 a=%h d=%h", n, mem_write, w_address, w_data, 12'h800 + 12'(n), 32'hC0DE_0000 + 32'(n));
                end
                n++;
            end
            step();
        end
        vectors++;
        if (n !== 17) begin miscompares++; $display("FAIL full_count: got %0d strobes expected 17", n); end
        vectors++;
        if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL full_empty_after: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_bypass();
        do_reset();
        vcount = 10'd200;
        bus_wr(12'hC00, 32'h1);
        step();
        bus_wr(12'h4FF, 32'h0000_1234);
        step();
        idle();
        vectors++;
        if (mem_write !== 3'b000) begin miscompares++; $display("FAIL bypass_latency: got %b expected 000", mem_write); end
        vectors++;
        if (fifo_level !== 5'd1) begin miscompares++; $display("FAIL bypass_level: got %0d expected 1", fifo_level); end
        step();
        vectors++;
        if (mem_write !== 3'b010) begin miscompares++; $display("FAIL bypass_strobe: got %b expected 010", mem_write); end
        vectors++;
        if (w_address !== 12'h4FF) begin miscompares++; $display("FAIL bypass_w_address: got %h expected 4ff", w_address); end
        vectors++;
        if (w_data !== 32'h0000_1234) begin miscompares++; $display("FAIL bypass_w_data: got %h expected 1234", w_data); end
        bus_wr(12'hC00, 32'h0);
        step();
        idle();
    endtask

    task automatic test_guard();
        int n;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus_wr(12'(i), 32'h6000_0000 + 32'(i));
            step();
        end
        idle();
        vectors++;
        if (fifo_level !== 5'd10) begin miscompares++; $display("FAIL guard_level10: got %0d expected 10", fifo_level); end
        vcount = 10'd523;
        step();
        vectors++;
        if (mem_write !== 3'b001 || w_address !== 12'h000) begin miscompares++; $display("FAIL guard_523_pop: got we=%b a=%h expected we=001 a=000", mem_write, w_address); end
        vcount = 10'd524;
        step();
        vectors++;
        if (fifo_level !== 5'd9) begin miscompares++; $display("FAIL guard_one_pop: got %0d expected 9", fifo_level); end
        step();
        vectors++;
        if (mem_write !== 3'b000) begin miscompares++; $display("FAIL guard_524_strobe: got %b expected 000", mem_write); end
        vcount = 10'd0;
        step();
        vcount = 10'd479;
        step();
        vectors++;
        if (fifo_level !== 5'd9 || mem_write !== 3'b000) begin miscompares++; $display("FAIL guard_active_hold: got level=%0d we=%b expected level=9 we=000", fifo_level, mem_write); end
        vcount = 10'd480;
        n = 1;
        for (int k = 0; k < 14; k++) begin
            step();
            if (mem_write !== 3'b000) begin
                vectors++;
                if (n > 9 || mem_write !== 3'b001 || w_address !== 12'(n) || w_data !== 32'h6000_0000 + 32'(n)) begin
                    miscompares++;
                    $display("FAIL guard_order: strobe %0d got we=%b a=%h d=%h", n, mem_write, w_address, w_data);
                end
                n++;
            end
        end
        vectors++;
        if (n !== 10) begin miscompares++; $display("FAIL guard_count: got %0d strobes expected 9", n - 1); end
    endtask

    task automatic test_reset_mid_drain();
        int cnt;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus_wr(12'h400 + 12'(i), $urandom);
            step();
        end
        idle();
        vcount = 10'd480;
        step();
        vectors++;
        if (mem_write !== 3'b010) begin miscompares++; $display("FAIL mid_drain_started: got %b expected 010", mem_write); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL mid_reset_level: got %0d expected 0", fifo_level); end
        vectors++;
        if (mem_write !== 3'b000) begin miscompares++; $display("FAIL mid_reset_we: got %b expected 000", mem_write); end
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mem_write !== 3'b000) cnt++;
        end
        vectors++;
        if (cnt !== 0) begin miscompares++; $display("FAIL mid_reset_no_strobes: got %0d strobes expected 0", cnt); end
    endtask

    task automatic test_irq();
        do_reset();
        vcount = 10'd479;
        step();
        vcount = 10'd480;
        step();
        vectors++;
        if (irq !== IRQ_EN) begin miscompares++; $display("FAIL irq_set: got %b expected %b", irq, IRQ_EN); end
        step();
        step();
        vectors++;
        if (irq !== IRQ_EN) begin miscompares++; $display("FAIL irq_sticky: got %b expected %b", irq, IRQ_EN); end
        bus_wr(12'hC01, 32'h0);
        step();
        idle();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
        vcount = 10'd479;
        step();
        vcount = 10'd480;
        bus_wr(12'hC01, 32'h0);
        step();
        idle();
        vectors++;
        if (irq !== IRQ_EN) begin miscompares++; $display("FAIL irq_set_wins: got %b expected %b", irq, IRQ_EN); end
        bus_wr(12'hC01, 32'h0);
        step();
        idle();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear2: got %b expected 0", irq); end
    endtask

    // Random traffic against a queue model: entries are {address[11:0], data}.
    task automatic test_random();
        logic [43:0] model_q[$];
        logic [43:0] popped;
        bit          bypass_m, irq_m, hold, is_data, is_ctrl, in_win, do_pop, exp_wait;
        logic [9:0]  prev_v;
        logic [2:0]  exp_we;
        logic [11:0] last_a;
        logic [31:0] last_d;
        int          r;
        bypass_m = 0; irq_m = 0; hold = 0;
        prev_v = '0; last_a = '0; last_d = '0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 7))
                    0: vcount = 10'd479;
                    1: vcount = 10'd480;
                    2: vcount = 10'd523;
                    3: vcount = 10'd524;
                    4: vcount = 10'd0;
                    default: vcount = 10'($urandom_range(0, 524));
                endcase
            end
            if (!hold) begin
                r = $urandom_range(0, 99);
                if (r < 55) begin
                    bus_wr({2'($urandom_range(0, 2)), 10'($urandom)}, $urandom);
                end else if (r < 59) begin
                    bus_wr({2'b11, 9'($urandom), 1'($urandom)}, 32'($urandom_range(0, 2) == 0));
                end else if (r < 65) begin
                    chipselect = 1'b0; write = 1'b1; address = 12'($urandom); writedata = $urandom;
                end else begin
                    idle();
                end
            end
            #1;
            is_data  = chipselect && write && (address[11:10] != 2'b11);
            is_ctrl  = chipselect && write && (address[11:10] == 2'b11);
            in_win   = (vcount >= 10'd480) && (vcount <= 10'd523);
            do_pop   = (model_q.size() > 0) && (bypass_m || in_win);
            exp_wait = is_data && (model_q.size() == DEPTH) && !do_pop;
            vectors++;
            if (waitrequest !== exp_wait || fifo_level !== 5'(model_q.size())) begin
                miscompares++;
                $display("FAIL rand_status cyc %0d: got wait=%b level=%0d expected wait=%b level=%0d", cyc, waitrequest, fifo_level, exp_wait, model_q.size());
            end
            step();
            exp_we = 3'b000;
            if (do_pop) begin
                popped = model_q.pop_front();
                last_a = popped[43:32];
                last_d = popped[31:0];
                exp_we = 3'b001 << popped[43:42];
            end
            if (is_data && !exp_wait) model_q.push_back({address, writedata});
            if (is_ctrl && !address[0]) bypass_m = writedata[0];
            if (IRQ_EN) begin
                if (is_ctrl && address[0]) irq_m = 0;
                if (prev_v == 10'd479 && vcount == 10'd480) irq_m = 1;
            end
            prev_v = vcount;
            hold = exp_wait;
            vectors++;
            if (mem_write !== exp_we || w_address !== last_a || w_data !== last_d || irq !== irq_m) begin
                miscompares++;
                $display("FAIL rand_port cyc %0d: got we=%b a=%h d=%h irq=%b expected we=%b a=%h d=%h irq=%b", cyc, mem_write, w_address, w_data, irq, exp_we, last_a, last_d, irq_m);
            end
        end
        idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vblank_drain();
        test_full_stall();
        test_bypass();
        test_guard();
        test_reset_mid_drain();
        test_irq();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
